// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI master (spi_protocol) and the SPI receiver.
package spi_pkg;
  localparam int DATA_WIDTH = 16;
  localparam logic SCLK_IDLE = 1'b0;
  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: N-stage flip-flop synchroniser with a parameterised reset value.
module spi_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [N-1:0] r_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_q <= {N{RST_VAL}};
    else        r_q <= {r_q[N-2:0], d};
  assign q = r_q[N-1];
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI receive end; deserialises MSB-first words into a valid/ready holding register
// and flags truncated frames and overruns.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = spi_pkg::DATA_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_cs_l,
  input  logic                  spi_sclk,
  input  logic                  spi_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [CNT_W-1:0]      bit_count,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun
);
  logic w_cs, w_sclk, w_data;
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1))      u_sync_cs   (.clk(clk), .reset(reset), .d(spi_cs_l), .q(w_cs));
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (.clk(clk), .reset(reset), .d(spi_sclk), .q(w_sclk));
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0))      u_sync_data (.clk(clk), .reset(reset), .d(spi_data), .q(w_data));
  logic                  r_cs_d, r_sclk_d;
  logic [SYNC_STAGES:0]  r_fill;
  logic [DATA_WIDTH-1:0] r_shreg, r_dout;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_valid, r_ferr, r_ovr;
  state_t                r_state;
  // Edges count only once both samples come from the pin rather than from reset
  // values, so a CS already low at reset release never looks like a fresh fall.
  logic w_live, w_sclk_rise, w_cs_fall, w_cs_rise, w_done;
  assign w_live      = r_fill[SYNC_STAGES];
  assign w_sclk_rise = w_live & w_sclk & ~r_sclk_d;
  assign w_cs_fall   = w_live & ~w_cs & r_cs_d;
  assign w_cs_rise   = w_live & w_cs & ~r_cs_d;
  assign w_done      = r_cnt == CNT_W'(DATA_WIDTH - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cs_d   <= 1'b1;
      r_sclk_d <= SCLK_IDLE;
      r_fill   <= '0;
      r_shreg  <= '0;
      r_dout   <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
      r_state  <= IDLE;
    end else begin
      r_cs_d   <= w_cs;
      r_sclk_d <= w_sclk;
      r_fill   <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
      if (r_valid && dout_ready) r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_shreg <= '0;
          r_cnt   <= '0;
          if (w_cs_fall) r_state <= RECV;
        end
        RECV: begin
          if (w_cs_rise) begin
            r_state <= IDLE;
            r_ferr  <= r_cnt != '0;
            r_cnt   <= '0;
            r_shreg <= '0;
          end else if (w_sclk_rise) begin
            r_shreg <= {r_shreg[DATA_WIDTH-2:0], w_data};
            r_cnt   <= w_done ? '0 : r_cnt + CNT_W'(1);
            if (w_done && (!r_valid || dout_ready)) begin
              r_dout  <= {r_shreg[DATA_WIDTH-2:0], w_data};
              r_valid <= 1'b1;
            end
            if (w_done && r_valid && !dout_ready) r_ovr <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign bit_count  = r_cnt;
  assign busy       = r_state == RECV;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed bench for spi_slave_rx with immediate-assertion checks.
module tb_spi_slave_rx;
  logic        clk = 1'b0, reset = 1'b0, spi_cs_l = 1'b0, spi_sclk = 1'b0, spi_data = 1'b0, dout_ready = 1'b1;
  logic [15:0] dout;
  logic        dout_valid, busy, frame_err, overrun;
  logic [4:0]  bit_count;
  int          n_cmp = 0, n_err = 0;
  int          n_acc = 0, n_vrise = 0, n_fe = 0, n_ov = 0;
  logic        v_prev = 1'b0;
  logic [15:0] words [64];
  int          b_acc, b_vr, b_fe, b_ov;

  spi_slave_rx dut (
    .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk), .spi_data(spi_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .bit_count(bit_count),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_valid && !v_prev) n_vrise++;
    v_prev = dout_valid;
    if (dout_valid && dout_ready && n_acc < 64) begin
      words[n_acc] = dout;
      n_acc++;
    end
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_data = w[15-i];
      spi_sclk = 1'b0;
      tick(4);
      spi_sclk = 1'b1;
      tick(4);
    end
    spi_sclk = 1'b0;
  endtask

  task automatic snap();
    b_acc = n_acc; b_vr = n_vrise; b_fe = n_fe; b_ov = n_ov;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      #5 spi_sclk = ~spi_sclk;
    end
    #2;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_bitcnt", 32'(bit_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    #4 spi_sclk = 1'b0;
    reset = 1'b1;
    tick(20);
    chk("cs_low_at_release_busy", 32'(busy), 32'h0);
    chk("cs_low_at_release_valid", 32'(n_vrise), 32'h0);
    spi_cs_l = 1'b1;
    tick(10);

    snap();
    spi_cs_l = 1'b0;
    tick(6);
    chk("t1_busy", 32'(busy), 32'h1);
    send(16'hACF1, 16);
    tick(8);
    chk("t1_acc_cnt", 32'(n_acc - b_acc), 32'h1);
    chk("t1_word", 32'(words[b_acc]), 32'hACF1);
    chk("t1_vpulses", 32'(n_vrise - b_vr), 32'h1);
    chk("t1_dout", 32'(dout), 32'hACF1);
    chk("t1_valid_cleared", 32'(dout_valid), 32'h0);
    chk("t1_bitcnt", 32'(bit_count), 32'h0);
    spi_cs_l = 1'b1;
    tick(8);
    chk("t1_ferr", 32'(n_fe - b_fe), 32'h0);
    chk("t1_idle", 32'(busy), 32'h0);

    snap();
    spi_cs_l = 1'b0;
    tick(6);
    send(16'h1234, 16);
    send(16'hBEEF, 16);
    tick(8);
    spi_cs_l = 1'b1;
    tick(8);
    chk("t2_acc_cnt", 32'(n_acc - b_acc), 32'h2);
    chk("t2_word0", 32'(words[b_acc]), 32'h1234);
    chk("t2_word1", 32'(words[b_acc+1]), 32'hBEEF);
    chk("t2_vpulses", 32'(n_vrise - b_vr), 32'h2);
    chk("t2_ferr", 32'(n_fe - b_fe), 32'h0);

    snap();
    spi_cs_l = 1'b0;
    tick(6);
    send(16'hA800, 7);
    tick(4);
    chk("t3_bitcnt7", 32'(bit_count), 32'h7);
    spi_cs_l = 1'b1;
    tick(8);
    chk("t3_ferr", 32'(n_fe - b_fe), 32'h1);
    chk("t3_no_valid", 32'(n_vrise - b_vr), 32'h0);
    chk("t3_busy", 32'(busy), 32'h0);
    chk("t3_bitcnt0", 32'(bit_count), 32'h0);
    snap();
    spi_cs_l = 1'b0;
    tick(6);
    send(16'h00FF, 16);
    tick(8);
    spi_cs_l = 1'b1;
    tick(8);
    chk("t3_acc_cnt", 32'(n_acc - b_acc), 32'h1);
    chk("t3_word", 32'(words[b_acc]), 32'h00FF);
    chk("t3_ferr_after", 32'(n_fe - b_fe), 32'h0);

    snap();
    dout_ready = 1'b0;
    spi_cs_l = 1'b0;
    tick(6);
    send(16'hAAAA, 16);
    send(16'h5555, 16);
    tick(8);
    chk("t4_dout_held", 32'(dout), 32'hAAAA);
    chk("t4_valid", 32'(dout_valid), 32'h1);
    chk("t4_overrun", 32'(n_ov - b_ov), 32'h1);
    spi_cs_l = 1'b1;
    tick(8);
    dout_ready = 1'b1;
    tick(2);
    chk("t4_valid_cleared", 32'(dout_valid), 32'h0);
    chk("t4_dout_after", 32'(dout), 32'hAAAA);
    chk("t4_acc_word", 32'(words[b_acc]), 32'hAAAA);
    chk("t4_acc_cnt", 32'(n_acc - b_acc), 32'h1);

    snap();
    spi_cs_l = 1'b0;
    tick(6);
    send(16'hFFFF, 9);
    tick(4);
    chk("t5_bitcnt9", 32'(bit_count), 32'h9);
    reset = 1'b0;
    #1;
    chk("t5_rst_bitcnt", 32'(bit_count), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_dout", 32'(dout), 32'h0);
    chk("t5_rst_valid", 32'(dout_valid), 32'h0);
    tick(4);
    reset = 1'b1;
    tick(10);
    chk("t5_wait_cs_high", 32'(busy), 32'h0);
    spi_cs_l = 1'b1;
    tick(6);
    snap();
    spi_cs_l = 1'b0;
    tick(6);
    send(16'h0F0F, 16);
    tick(8);
    chk("t5_dout", 32'(dout), 32'h0F0F);
    spi_cs_l = 1'b1;
    tick(8);
    chk("t5_acc_word", 32'(words[b_acc]), 32'h0F0F);
    chk("t5_ferr", 32'(n_fe - b_fe), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
